// File: rtl/led_pkg.sv
// Shared types and reset defaults for the multi-channel LED pattern generator.
// Channel modes are encoded so that a raw 2-bit config field casts directly to led_mode_t.
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF     = 2'd0,
      LED_ON      = 2'd1,
      LED_BLINK   = 2'd2,
      LED_BREATHE = 2'd3
   } led_mode_t;

   localparam int        DEF_PERIOD = 1000;
   localparam int        DEF_ON     = 500;
   localparam led_mode_t DEF_MODE   = LED_BLINK;

endpackage

// File: rtl/led_tick_gen.sv
// Timebase prescaler: counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
// TICK_DIV must be at least 2 so that tick is a true single-cycle pulse.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int TICK_DIV = 12_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// N_CH independent LED channels (OFF/ON/BLINK/BREATHE) sharing one millisecond tick
// and one free-running PWM carrier; every LED pin is driven from a flop.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int CLK_HZ   = 12_000_000,
   parameter int TICK_HZ  = 1000,
   parameter int N_CH     = 4,
   parameter int TW       = 16,
   parameter int PWM_BITS = 8
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          cfg_we,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]    cfg_ch,
   input  logic [1:0]                                    cfg_mode,
   input  logic [TW-1:0]                                 cfg_period,
   input  logic [TW-1:0]                                 cfg_on,
   input  logic                                          sync,
   output logic                                          tick,
   output logic [N_CH-1:0]                               led
);

   localparam int                  TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int                  CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;

   // Wrapping phase step; the >= compare also pulls a phase left above a shrunk period back to 0.
   function automatic logic [TW-1:0] phase_step(input logic [TW-1:0] phase,
                                                input logic [TW-1:0] period);
      if (period == '0) begin
         return '0;
      end
      if (phase >= period - TW'(1)) begin
         return '0;
      end
      return phase + TW'(1);
   endfunction

   logic [PWM_BITS-1:0] carrier;
   logic [N_CH-1:0]     led_next;

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carrier <= '0;
      end else begin
         carrier <= carrier + PWM_BITS'(1);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      led_mode_t           mode;
      logic [TW-1:0]       period;
      logic [TW-1:0]       on_time;
      logic [TW-1:0]       phase;
      logic [PWM_BITS-1:0] level;
      logic                dir_down;
      logic                wr;
      logic                clr;
      logic                ch_next;

      // Out-of-range channel numbers simply match no channel.
      assign wr  = cfg_we && (cfg_ch == CH_W'(i));
      assign clr = wr || sync;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mode    <= DEF_MODE;
            period  <= TW'(DEF_PERIOD);
            on_time <= TW'(DEF_ON);
         end else if (wr) begin
            mode    <= led_mode_t'(cfg_mode);
            period  <= cfg_period;
            on_time <= cfg_on;
         end
      end

      // Clearing wins over a coincident tick so a restarted pattern begins at phase 0.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            phase    <= '0;
            level    <= '0;
            dir_down <= 1'b0;
         end else if (clr) begin
            phase    <= '0;
            level    <= '0;
            dir_down <= 1'b0;
         end else if (tick) begin
            phase <= phase_step(phase, period);
            if (!dir_down) begin
               level <= level + PWM_BITS'(1);
               if (level == LVL_MAX - PWM_BITS'(1)) begin
                  dir_down <= 1'b1;
               end
            end else begin
               level <= level - PWM_BITS'(1);
               if (level == PWM_BITS'(1)) begin
                  dir_down <= 1'b0;
               end
            end
         end
      end

      always_comb begin
         ch_next = 1'b0;
         case (mode)
            LED_OFF:     ch_next = 1'b0;
            LED_ON:      ch_next = 1'b1;
            LED_BLINK:   ch_next = (period != '0) && (phase < on_time);
            LED_BREATHE: ch_next = (level > carrier);
            default:     ch_next = 1'b0;
         endcase
      end

      assign led_next[i] = ch_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else begin
         led <= led_next;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at TICK_DIV=10: default blink, config table,
// breathe ramp and PWM, sync/config collision and asynchronous reset.
`timescale 1ns/1ps
module tb_led_pattern_gen;
   import led_pkg::*;

   localparam int N_CH     = 4;
   localparam int TW       = 16;
   localparam int PWM_BITS = 8;
   localparam int NV       = 8;

   typedef struct {
      logic [1:0]  ch;
      logic [1:0]  mode;
      logic [15:0] period;
      logic [15:0] on;
      logic [7:0]  pat;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cfg_we = 1'b0;
   logic [1:0]      cfg_ch = '0;
   logic [1:0]      cfg_mode = '0;
   logic [TW-1:0]   cfg_period = '0;
   logic [TW-1:0]   cfg_on = '0;
   logic            sync = 1'b0;
   logic            tick;
   logic [N_CH-1:0] led;

   int checks = 0;
   int errors = 0;
   int clk_cnt;
   vec_t vec [NV];

   led_pattern_gen #(
      .CLK_HZ   (10_000),
      .TICK_HZ  (1000),
      .N_CH     (N_CH),
      .TW       (TW),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_on     (cfg_on),
      .sync       (sync),
      .tick       (tick),
      .led        (led)
   );

   always #5 clk = ~clk;

   // Edges since reset release; equals the DUT carrier and, mod 10, its prescaler.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) clk_cnt <= 0;
      else        clk_cnt <= clk_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_tick_cycle();
      int n = 0;
      while (tick !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (tick !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL tick_wait: no tick within 20 cycles");
      end
   endtask

   task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode,
                            input logic [15:0] per, input logic [15:0] on);
      cfg_ch     = ch;
      cfg_mode   = mode;
      cfg_period = per;
      cfg_on     = on;
      cfg_we     = 1'b1;
      @(negedge clk);
      cfg_we     = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, nt, n, hi, exp_hi;
      logic [7:0] lvl_m, c_now, l_now;
      logic t_now, exp_led;
      logic [7:0] pat6;

      vec[0] = '{2'd1, LED_BLINK, 16'd4, 16'd1, 8'b0001_0001};
      vec[1] = '{2'd2, LED_BLINK, 16'd5, 16'd7, 8'b1111_1111};
      vec[2] = '{2'd2, LED_BLINK, 16'd0, 16'd7, 8'b0000_0000};
      vec[3] = '{2'd2, LED_BLINK, 16'd3, 16'd2, 8'b1101_1011};
      vec[4] = '{2'd1, LED_BLINK, 16'd2, 16'd0, 8'b0000_0000};
      vec[5] = '{2'd3, LED_OFF,   16'd4, 16'd1, 8'b0000_0000};
      vec[6] = '{2'd3, LED_ON,    16'd4, 16'd1, 8'b1111_1111};
      vec[7] = '{2'd1, LED_BLINK, 16'd3, 16'd3, 8'b1111_1111};

      // Reset state and default 1 s blink
      #23;
      check("reset_led", led, 0);
      check("reset_tick", tick, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_led", led, 4'hF);
      bad = 0;
      nt  = 0;
      while (clk_cnt < 10001) begin
         if (tick !== ((clk_cnt % 10) == 9)) bad++;
         if (tick === 1'b1) nt++;
         if (clk_cnt == 5000)  check("blink_high_end", led, 4'hF);
         if (clk_cnt == 5001)  check("blink_low_start", led, 4'h0);
         if (clk_cnt == 10000) check("blink_low_end", led, 4'h0);
         @(negedge clk);
      end
      check("blink_rise_again", led, 4'hF);
      check("tick_position", bad, 0);
      check("tick_count", nt, 1000);

      // OFF then ON, new value visible on the second edge after the strobe
      write_cfg(2'd3, LED_OFF, 16'd1000, 16'd500);
      check("off_lag", led[3], 1);
      @(negedge clk);
      check("off_applied", led[3], 0);
      check("off_others", led[2:0], 3'b111);
      write_cfg(2'd3, LED_ON, 16'd1000, 16'd500);
      check("on_lag", led[3], 0);
      @(negedge clk);
      check("on_applied", led[3], 1);

      // Config table: led[ch] sampled mid-tick for 8 ticks after a tick-aligned write
      for (int e = 0; e < NV; e++) begin
         wait_tick_cycle();
         write_cfg(vec[e].ch, vec[e].mode, vec[e].period, vec[e].on);
         repeat (5) @(negedge clk);
         for (int j = 0; j < 8; j++) begin
            check($sformatf("vec%0d_tick%0d", e, j), led[vec[e].ch], vec[e].pat[j]);
            if (j < 7) repeat (10) @(negedge clk);
         end
      end

      // period=0 holds phase at 0
      write_cfg(2'd2, LED_BLINK, 16'd0, 16'd7);
      repeat (35) @(negedge clk);
      check("period0_phase", dut.g_ch[2].phase, 0);
      check("period0_led", led[2], 0);

      // BREATHE ramp up to 255, down to 0, then straight back up
      write_cfg(2'd0, LED_BREATHE, 16'd0, 16'd0);
      nt = 0;
      n  = 0;
      while (nt < 255 && n < 4000) begin
         if (tick === 1'b1) nt++;
         @(negedge clk);
         n++;
      end
      check("breathe_peak", dut.g_ch[0].level, 255);
      while (nt < 510 && n < 8000) begin
         if (tick === 1'b1) nt++;
         @(negedge clk);
         n++;
      end
      check("breathe_trough", dut.g_ch[0].level, 0);
      while (nt < 638 && n < 10000) begin
         if (tick === 1'b1) nt++;
         @(negedge clk);
         n++;
      end
      check("breathe_mid", dut.g_ch[0].level, 128);

      // PWM window: level tracked from tick count, carrier from edge count
      lvl_m  = 8'd128;
      bad    = 0;
      hi     = 0;
      exp_hi = 0;
      for (int k = 0; k < 256; k++) begin
         t_now = tick;
         c_now = 8'(clk_cnt % 256);
         l_now = lvl_m;
         @(negedge clk);
         exp_led = (l_now > c_now);
         if (led[0] === 1'b1) hi++;
         if (exp_led) exp_hi++;
         if (led[0] !== exp_led) bad++;
         if (t_now) lvl_m = lvl_m + 8'd1;
      end
      check("pwm_cycle_errors", bad, 0);
      check("pwm_duty", hi, exp_hi);

      // sync together with a tick and a config write to ch1
      write_cfg(2'd3, LED_BLINK, 16'd6, 16'd3);
      repeat (25) @(negedge clk);
      wait_tick_cycle();
      sync = 1'b1;
      write_cfg(2'd1, LED_BLINK, 16'd6, 16'd3);
      sync = 1'b0;
      check("sync_phase0", dut.g_ch[0].phase, 0);
      check("sync_phase1", dut.g_ch[1].phase, 0);
      check("sync_phase2", dut.g_ch[2].phase, 0);
      check("sync_phase3", dut.g_ch[3].phase, 0);
      check("sync_level0", dut.g_ch[0].level, 0);
      check("sync_cfg_period1", dut.g_ch[1].period, 6);
      @(negedge clk);
      check("sync_hold1", dut.g_ch[1].phase, 0);
      check("sync_hold3", dut.g_ch[3].phase, 0);
      repeat (4) @(negedge clk);
      pat6 = 8'b1100_0111;
      for (int j = 0; j < 8; j++) begin
         check($sformatf("sync_ch1_tick%0d", j), led[1], pat6[j]);
         check($sformatf("sync_ch3_tick%0d", j), led[3], pat6[j]);
         if (j < 7) repeat (10) @(negedge clk);
      end

      // Asynchronous reset mid-pattern
      write_cfg(2'd3, LED_ON, 16'd6, 16'd3);
      @(negedge clk);
      check("pre_reset_on", led[3], 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_led", led, 0);
      check("async_reset_tick", tick, 0);
      check("reset_period", dut.g_ch[1].period, 1000);
      check("reset_on", dut.g_ch[1].on_time, 500);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rerelease_led", led, 4'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
